// File: rtl/nibble_packer.sv
// nibble_packer: packs NIBBLES consecutive 4-bit slices into one wide word
// behind a single output holding register. A flush emits a partial word early.
// Optional build macro NIBBLE_PACKER_MSB_FIRST_EN: when defined, the first
// nibble lands in the top nibble, so partial words are left-justified.
module nibble_packer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_nibble,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_data,
  output logic [3:0]           out_count,
  output logic                 out_last
);

  localparam int W = 4 * NIBBLES;
  localparam logic [3:0] LAST_IDX = 4'(NIBBLES - 1);

  logic [W-1:0] acc_r;
  logic [3:0]   cnt_r;
  logic         flush_pend_r;
  logic         out_valid_r;
  logic [W-1:0] out_data_r;
  logic [3:0]   out_count_r;
  logic         out_last_r;

  logic         slot_free_s;
  logic         in_ready_s;
  logic         accept_s;
  logic         honor_s;
  logic         complete_s;
  logic [3:0]   place_idx_s;
  logic [3:0]   cnt_ins_s;
  logic [W-1:0] acc_ins_s;

  // Handshake decode and the accumulator contents after inserting this cycle's nibble.
  always_comb begin
    slot_free_s = !out_valid_r || out_ready;
    // The completing nibble needs a free output slot; a pending flush blocks input.
    in_ready_s  = !flush_pend_r && ((cnt_r != LAST_IDX) || slot_free_s);
    accept_s    = in_valid && in_ready_s;
    honor_s     = (flush || flush_pend_r) && slot_free_s;
    complete_s  = accept_s && (cnt_r == LAST_IDX);
`ifdef NIBBLE_PACKER_MSB_FIRST_EN
    place_idx_s = LAST_IDX - cnt_r;
`else
    place_idx_s = cnt_r;
`endif
    if (accept_s) begin
      cnt_ins_s = cnt_r + 4'd1;
    end else begin
      cnt_ins_s = cnt_r;
    end
    acc_ins_s = acc_r;
    for (int i = 0; i < NIBBLES; i++) begin
      if (accept_s && (place_idx_s == 4'(i))) begin
        acc_ins_s[4*i +: 4] = in_nibble;
      end else begin
        acc_ins_s[4*i +: 4] = acc_r[4*i +: 4];
      end
    end
  end

  // Accumulator, flush tracking and the output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r        <= '0;
      cnt_r        <= 4'd0;
      flush_pend_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_count_r  <= 4'd0;
      out_last_r   <= 1'b0;
    end else begin
      // A full word, or an honored flush with something to send, loads the output.
      if (complete_s || (honor_s && (cnt_ins_s != 4'd0))) begin
        out_valid_r <= 1'b1;
        out_data_r  <= acc_ins_s;
        out_count_r <= cnt_ins_s;
        out_last_r  <= honor_s;
        acc_r       <= '0;
        cnt_r       <= 4'd0;
      end else begin
        // Nothing to load: drain if the consumer takes the word, else hold.
        out_valid_r <= out_valid_r && !out_ready;
        acc_r       <= acc_ins_s;
        cnt_r       <= cnt_ins_s;
      end
      if (honor_s) begin
        flush_pend_r <= 1'b0;
      end else if (flush) begin
        flush_pend_r <= 1'b1;
      end else begin
        flush_pend_r <= flush_pend_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_count = out_count_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_nibble_packer.sv
// Scoreboard bench for nibble_packer (NIBBLES = 4). Directed stimulus pushes
// hand-computed words; a negedge monitor pops and compares on each transfer.
module tb_nibble_packer;

  localparam int N = 4;

`ifdef NIBBLE_PACKER_MSB_FIRST_EN
  localparam logic [15:0] E1  = 16'h1234;
  localparam logic [15:0] E2  = 16'h5600;
  localparam logic [15:0] E4  = 16'h5678;
  localparam logic [15:0] E5A = 16'h9ABC;
  localparam logic [15:0] E5B = 16'h1200;
  localparam logic [15:0] E6  = 16'h3456;
  localparam logic [15:0] E7  = 16'hABCD;
`else
  localparam logic [15:0] E1  = 16'h4321;
  localparam logic [15:0] E2  = 16'h0065;
  localparam logic [15:0] E4  = 16'h8765;
  localparam logic [15:0] E5A = 16'hCBA9;
  localparam logic [15:0] E5B = 16'h0021;
  localparam logic [15:0] E6  = 16'h6543;
  localparam logic [15:0] E7  = 16'hDCBA;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  count;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_nibble;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_count;
  logic        out_last;

  exp_t sb[$];
  int   n_checks;
  int   n_pass;

  nibble_packer #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_nibble (in_nibble),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] c, input logic l);
    exp_t e;
    e.data = d;
    e.count = c;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one nibble and wait (bounded) until it is accepted.
  task automatic send(input logic [3:0] n);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_nibble = n;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        step();
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: nibble %h never accepted", n);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Monitor: every transfer on the output side must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got %h count %0d, none expected", out_data, out_count);
      end else begin
        e = sb.pop_front();
        check("word_data", 32'(out_data), 32'(e.data));
        check("word_count", 32'(out_count), 32'(e.count));
        check("word_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_nibble = 4'h0;
    flush = 1'b0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();

    // Full word, back to back, visible the cycle after the 4th accept
    push(E1, 4'd4, 1'b0);
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    @(negedge clk);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_data", 32'(out_data), 32'(E1));
    step();

    // Partial word via flush, then a flush with nothing held is dropped
    push(E2, 4'd2, 1'b1);
    send(4'h5); send(4'h6);
    pulse_flush();
    step();
    pulse_flush();
    @(negedge clk);
    check("empty_flush_no_valid", 32'(out_valid), 32'd0);
    step(); step();

    // Backpressure: word 1 held, 5..7 accepted, 8th stalls
    push(E1, 4'd4, 1'b0);
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    out_ready = 1'b0;
    send(4'h5); send(4'h6); send(4'h7);
    in_valid = 1'b1;
    in_nibble = 4'h8;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'(E1));
      step();
    end
    push(E4, 4'd4, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_word2_valid", 32'(out_valid), 32'd1);
    check("bp_word2_data", 32'(out_data), 32'(E4));
    step();
    out_ready = 1'b1;
    step();

    // Flush while the output register is full becomes pending
    push(E5A, 4'd4, 1'b0);
    send(4'h9); send(4'hA); send(4'hB); send(4'hC);
    out_ready = 1'b0;
    send(4'h1); send(4'h2);
    push(E5B, 4'd2, 1'b1);
    pulse_flush();
    @(negedge clk);
    check("pend_in_ready_low", 32'(in_ready), 32'd0);
    check("pend_hold_data", 32'(out_data), 32'(E5A));
    step(); step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("pend_partial_valid", 32'(out_valid), 32'd1);
    step();
    @(negedge clk);
    check("pend_cleared_in_ready", 32'(in_ready), 32'd1);
    step();

    // Flush coincident with the completing nibble
    push(E6, 4'd4, 1'b1);
    send(4'h3); send(4'h4); send(4'h5);
    flush = 1'b1;
    send(4'h6);
    flush = 1'b0;
    step();

    // Reset mid-word discards the partial word
    send(4'h1); send(4'h2);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    push(E7, 4'd4, 1'b0);
    send(4'hA); send(4'hB); send(4'hC); send(4'hD);

    // Bounded drain of the scoreboard
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    step(); step();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
